// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus bundle between the processor and the memory-mapped UART transmitter.
// The master drives address, write data, byte enables and read strobe; the slave returns registered read data.
interface uart_tx_mmio_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_wmask,
    output mem_rstrb,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_wmask,
    input  mem_rstrb,
    output mem_rdata
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to TXDATA are queued in a FIFO and shifted out on txd.
// Reads return one cycle after the strobe; a store into a full FIFO is dropped and sets sticky overflow.
module uart_tx_mmio #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16,
  parameter int IO_BIT      = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_mmio_if.slave        bus,
  output logic                 txd
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = $clog2(DIV);

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic [31:0]   rdata_q, rdata_d;

  logic        sel;
  logic [1:0]  offset;
  logic        full, empty, busy;
  logic        push_req, push, pop;
  logic        ovf_set, ovf_clr;
  logic [31:0] status;
  logic        unused_bits;

  assign sel    = bus.mem_addr[IO_BIT];
  assign offset = bus.mem_addr[3:2];
  assign full   = (count_q == CNT_FULL);
  assign empty  = (count_q == '0);
  assign busy   = (state_q != ST_IDLE);

  // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
  assign push_req = sel && (offset == 2'd0) && bus.mem_wmask[0];
  assign push     = push_req && !full;
  assign ovf_set  = push_req && full;
  assign ovf_clr  = sel && (offset == 2'd1) && bus.mem_wmask[0] && bus.mem_wdata[3];

  assign unused_bits = ^{bus.mem_addr, bus.mem_wdata, bus.mem_wmask};

  always_comb begin
    status        = '0;
    status[0]     = busy;
    status[1]     = full;
    status[2]     = empty;
    status[3]     = ovf_q;
    status[4 +: CW] = count_q;
  end

  always_comb begin
    rdata_d = '0;
    if (bus.mem_rstrb && sel && (offset == 2'd1)) begin
      rdata_d = status;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        // Chain straight into the next start bit when more data is queued.
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
    endcase

    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      rdata_q  <= rdata_d;
    end
  end

  assign txd           = txd_q;
  assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboarded bench for uart_tx_mmio: expected reads and frames are queued by the stimulus,
// and independent monitors check registered read data and decode txd frames at mid-bit.
module tb_uart_tx_mmio;

  localparam int DIV = 10;
  localparam logic [31:0] A_TXD  = 32'h0040_0000;
  localparam logic [31:0] A_STAT = 32'h0040_0004;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  logic clk;
  logic rst;
  logic txd;
  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .CLK_FREQ_HZ(10),
    .BAUD       (1),
    .FIFO_DEPTH (16),
    .IO_BIT     (22)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .txd(txd)
  );

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          last_acc = 0;
  frame_t      tx_q[$];
  logic [31:0] rd_q[$];
  logic        rd_seen;

  logic        dec_active = 1'b0;
  int          dec_cyc = 0;
  int          dec_start = 0;
  logic [7:0]  dec_byte = 8'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wmask = m;
    last_acc      = cyc + 1;
    @(negedge clk);
    bus.mem_wmask = 4'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    bus.mem_addr  = a;
    bus.mem_rstrb = 1'b1;
    rd_q.push_back(e);
    @(negedge clk);
    bus.mem_rstrb = 1'b0;
  endtask

  task automatic exp_frame(input logic [7:0] b, input int start);
    frame_t f;
    f.b     = b;
    f.start = start;
    tx_q.push_back(f);
  endtask

  // Read monitor: data is due on the cycle after the strobe is sampled.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_seen <= 1'b0;
    else     rd_seen <= bus.mem_rstrb;
  end

  always @(negedge clk) begin
    if (rd_seen && !rst) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rdata: unexpected read response 0x%0h", bus.mem_rdata);
      end else begin
        check("rdata", bus.mem_rdata, rd_q.pop_front());
      end
    end
  end

  // Frame monitor: detect the start edge, sample each bit at its midpoint.
  always @(negedge clk) begin
    if (rst) begin
      dec_active = 1'b0;
    end else begin
      if (!dec_active) begin
        if (txd == 1'b0) begin
          dec_active = 1'b1;
          dec_cyc    = 0;
          dec_start  = cyc;
        end
      end else begin
        dec_cyc++;
      end
      if (dec_active) begin
        if (dec_cyc % DIV == DIV / 2) begin
          if (dec_cyc / DIV == 0) begin
            check("start_bit", {31'b0, txd}, 32'h0);
          end else if (dec_cyc / DIV <= 8) begin
            dec_byte[dec_cyc / DIV - 1] = txd;
          end else begin
            check("stop_bit", {31'b0, txd}, 32'h1);
            if (tx_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL frame: unexpected frame byte 0x%0h at cycle %0d", dec_byte, dec_start);
            end else begin
              frame_t f;
              f = tx_q.pop_front();
              check("frame_byte", {24'b0, dec_byte}, {24'b0, f.b});
              check("frame_start_cycle", dec_start, f.start);
            end
          end
        end
        if (dec_cyc == 10 * DIV - 1) dec_active = 1'b0;
      end
    end
  end

  initial begin
    int s;
    rst           = 1'b1;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    bus.mem_rstrb = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("reset_txd", {31'b0, txd}, 32'h1);
    check("reset_rdata", bus.mem_rdata, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_txd", {31'b0, txd}, 32'h1);
    check("idle_rdata", bus.mem_rdata, 32'h0);
    rd(A_STAT, 32'h4);

    // Single byte: busy during the frame, idle afterwards
    wr(A_TXD, 32'h55, 4'b0001);
    exp_frame(8'h55, last_acc + 1);
    repeat (30) @(negedge clk);
    rd(A_STAT, 32'h5);
    repeat (100) @(negedge clk);
    rd(A_STAT, 32'h4);

    // Back-to-back frames, one byte waiting in the FIFO
    wr(A_TXD, 32'hA3, 4'b0001);
    s = last_acc + 1;
    wr(A_TXD, 32'h0F, 4'b0001);
    exp_frame(8'hA3, s);
    exp_frame(8'h0F, s + 100);
    repeat (20) @(negedge clk);
    rd(A_STAT, 32'h11);
    repeat (200) @(negedge clk);
    rd(A_STAT, 32'h4);

    // Overflow: 18 stores, one lands in the shifter, 16 fill the FIFO, the last is dropped
    s = 0;
    for (int i = 0; i < 18; i++) begin
      wr(A_TXD, 32'h10 + i, 4'b0001);
      if (i == 0) s = last_acc + 1;
    end
    for (int i = 0; i < 17; i++) exp_frame(8'h10 + 8'(i), s + 100 * i);
    rd(A_STAT, 32'h10B);
    wr(A_STAT, 32'h8, 4'b0001);
    rd(A_STAT, 32'h103);
    // Store lands on the edge where the FSM pops while the FIFO is full: still rejected
    while (cyc < s + 99) @(negedge clk);
    wr(A_TXD, 32'hEE, 4'b0001);
    rd(A_STAT, 32'hF9);
    wr(A_STAT, 32'h8, 4'b0001);
    rd(A_STAT, 32'hF1);
    repeat (1700) @(negedge clk);
    rd(A_STAT, 32'h4);

    // Decode isolation
    wr(32'h0000_0000, 32'h77, 4'b0001);
    wr(A_TXD, 32'h77, 4'b0010);
    wr(32'h0040_0008, 32'h77, 4'b0001);
    rd(32'h0000_0004, 32'h0);
    rd(32'h0040_0008, 32'h0);
    rd(A_STAT, 32'h4);
    repeat (30) @(negedge clk);
    check("isolation_txd", {31'b0, txd}, 32'h1);

    // Mid-frame reset during data bit 3 (0xC6 bit 3 is 0)
    wr(A_TXD, 32'hC6, 4'b0001);
    s = last_acc + 1;
    while (cyc < s + 44) @(negedge clk);
    check("pre_reset_txd", {31'b0, txd}, 32'h0);
    #1 rst = 1'b1;
    #1 check("async_reset_txd", {31'b0, txd}, 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd(A_STAT, 32'h4);
    wr(A_TXD, 32'h3C, 4'b0001);
    exp_frame(8'h3C, last_acc + 1);
    repeat (110) @(negedge clk);
    rd(A_STAT, 32'h4);
    repeat (3) @(negedge clk);

    check("frames_outstanding", tx_q.size(), 32'h0);
    check("reads_outstanding", rd_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
